bit_normalizer: RTL
===================

# bit_normalizer

Sequential normalizer, the inverse of the barrel shifter in the same design. The shifter takes a word and a shift amount and produces a shifted word. This block takes a word and recovers the shift: it finds the first set bit from a selected end, shifts the word until that bit reaches the edge, and reports the shift amount. It sits upstream of the shifter datapath, uses valid/ready handshakes on both sides, and scans one bit per cycle.

## Interface
- N, default 16: data width; must be a power of two, at least 2.
- AW, default $clog2(N) (4 for N=16): shift-amount width; matches the shifter's amount port.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data and in_dir are valid.
- in_ready  output  1  block can accept a word (state IDLE).
- in_data  input  N  word to normalize.
- in_dir  input  1  1 = leading-zero direction (normalize toward bit N-1); 0 = trailing-zero direction (normalize toward bit 0).
- out_valid  output  1  result is valid (state DONE).
- out_ready  input  1  consumer accepts the result.
- out_data  output  N  normalized word, in the original bit orientation.
- out_amount  output  AW  number of single-bit shifts applied.
- out_zero  output  1  in_data was all zeros.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, load the work register with in_data when in_dir=1, or with bit-reversed in_data when in_dir=0.
  - Latch in_dir and clear the counter.
  - If in_data==0: go to DONE with zero flag=1, amount=0, data=0. Otherwise go to SCAN.
- SCAN, each cycle:
  - If work[N-1]==1: go to DONE.
  - Otherwise shift work left by 1, fill 0, and increment count.
  - A nonzero word always terminates, with count ≤ N-1. No counter overflow is possible.
- DONE:
  - out_valid=1.
  - out_data = work when the latched dir=1, or bit-reverse(work) when dir=0.
  - out_amount = count; out_zero = zero flag.
  - Hold all outputs stable until out_ready. On out_valid&&out_ready, go to IDLE.
- in_ready and out_valid are never both 1. in_valid is ignored outside IDLE.
- Invariant, nonzero input:
  - dir=1: in_data << out_amount == out_data.
  - dir=0: in_data >> out_amount == out_data.
  - The shifter driven with (out_data, out_amount, opposite direction) reproduces in_data.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE.
  - in_ready=1, out_valid=0, out_data=0, out_amount=0, out_zero=0.
  - Internal work register, counter and flags are cleared.
- Reset asserted in SCAN or DONE aborts the operation; the result is discarded and never presented.
- Latency is measured from the accept edge to the edge after which out_valid=1:
  - Nonzero input with z leading (or trailing) zeros: z+1 edges.
  - Zero input: 1 edge.
- Throughput: one result per z+2 cycles minimum, since the DONE→IDLE edge costs one cycle. With out_ready held high, out_valid is high for exactly one cycle.
- Back-pressure: out_ready low holds DONE indefinitely; outputs must not change.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.

## Structure
- Package norm_pkg holds:
  - state enum {IDLE, SCAN, DONE}
  - localparam N_DEFAULT=16
- Sub-module bit_reverse #(N): purely combinational mirror. Two instances: one on the load path, one on the output path.
- FSM, work register and counter live in bit_normalizer.

## Test plan
- Reset mid-SCAN:
  - Stimulus: accept 0x0001 with dir=1, then pulse rst_n low on the 5th cycle.
  - Required: in_ready=1 and out_valid=0 immediately. A following accept of 0x8000 with dir=1 yields amount 0.
- Leading direction:
  - Stimulus: in_data=0x0F00, dir=1, out_ready=1.
  - Required: out_valid rises 5 edges after accept; out_data=0xF000, out_amount=4, out_zero=0.
- Trailing direction:
  - Stimulus: in_data=0x0F00, dir=0.
  - Required: out_data=0x000F, out_amount=8, latency 9 edges.
- Zero and worst case:
  - Stimulus: in_data=0x0000, then in_data=0x0001 with dir=1.
  - Required: first result out_zero=1, amount 0, latency 1. Second result out_data=0x8000, amount 15, latency 16.
- Back-pressure:
  - Stimulus: in_data=0x0003 with dir=1; hold out_ready=0 for 10 cycles, then raise it.
  - Required: out_data=0xC000 and amount 14 held stable throughout. in_ready stays 0 until one cycle after the handshake. in_valid pulses during DONE are ignored.
- Randomized round-trip:
  - Stimulus: 1000 random words and directions, with the result fed to the barrel shifter in the opposite direction.
  - Required: the shifter reproduces in_data for every nonzero word.

Source files
------------

// File: rtl/norm_pkg.sv
// Shared types for the bit normalizer: FSM state encoding and default width.
// Pure declarations; no logic, no latency, no flow control of its own.
package norm_pkg;
  localparam int N_DEFAULT = 16;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/bit_reverse.sv
// Combinational mirror of an N-bit word (bit i <-> bit N-1-i).
// Zero latency; no handshake, just a wiring permutation.
module bit_reverse #(
  parameter int N = 16
) (
  input  logic [N-1:0] data,
  output logic [N-1:0] mirrored
);
  for (genvar i = 0; i < N; i++) begin : g_rev
    assign mirrored[i] = data[N-1-i];
  end
endmodule

// File: rtl/bit_normalizer.sv
// Normalizer: shifts a word one bit per cycle until its first set bit reaches the chosen edge; reports the shift.
// Latency z+1 edges including accept (1 for zero words); out_ready low parks the result in DONE, outputs frozen.
module bit_normalizer
  import norm_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_dir,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [AW-1:0] out_amount,
  output logic          out_zero
);
  state_t        state;
  logic [N-1:0]  work;
  logic [N-1:0]  work_rev;
  logic [N-1:0]  in_rev;
  logic [N-1:0]  load_word;
  logic [AW-1:0] count;
  logic          dir_q;
  logic          zero_q;

  bit_reverse #(.N(N)) u_rev_in  (.data(in_data), .mirrored(in_rev));
  bit_reverse #(.N(N)) u_rev_out (.data(work),    .mirrored(work_rev));

  // Trailing-zero requests are mirrored so the scan always runs toward bit N-1.
  assign load_word  = in_dir ? in_data : in_rev;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign out_data   = dir_q ? work : work_rev;
  assign out_amount = count;
  assign out_zero   = zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      work   <= '0;
      count  <= '0;
      dir_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work   <= load_word;
            dir_q  <= in_dir;
            count  <= '0;
            zero_q <= (in_data == '0);
            // Already-normalized and all-zero words finish on the accept edge.
            if ((in_data == '0) || load_word[N-1]) state <= DONE;
            else                                   state <= SCAN;
          end
        end
        SCAN: begin
          work  <= {work[N-2:0], 1'b0};
          count <= count + AW'(1);
          // Look one bit ahead so the final shift and the exit share an edge.
          if (work[N-2]) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
